// File: rtl/key_schedule.sv
// AES-128 key expansion: produces one round key per clock, streams it out and
// stores it in an 11-entry table that can be read at random.
module key_schedule #(
  parameter int unsigned ROUNDS = 10
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [0:127] cipher_key,
  output logic         busy,
  output logic         round_key_valid,
  output logic [0:127] round_key,
  output logic [3:0]   round_index,
  output logic         done,
  input  logic [3:0]   rd_index,
  output logic [0:127] rd_key,
  output logic         table_valid
);

  localparam logic [3:0] LAST_ROUND = 4'(ROUNDS);

  // Element 255 holds S-box entry 0x00, so entry x lives at index ~x.
  localparam logic [255:0][7:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };

  typedef enum logic {IDLE, EXPAND} state_e;

  state_e        state_q, state_d;
  logic [3:0]    round_cnt_q, round_cnt_d;
  logic [127:0]  work_key_q, work_key_d;
  logic [127:0]  round_key_q, round_key_d;
  logic [3:0]    round_index_q, round_index_d;
  logic          key_valid_q, key_valid_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          table_valid_q, table_valid_d;
  logic          table_we;
  logic [127:0]  next_key;
  logic [127:0]  key_table_q [ROUNDS+1];

  function automatic logic [7:0] sbox(input logic [7:0] x);
    return SBOX[~x];
  endfunction

  function automatic logic [7:0] rcon(input logic [3:0] r);
    logic [7:0] rc;
    case (r)
      4'd1:    rc = 8'h01;
      4'd2:    rc = 8'h02;
      4'd3:    rc = 8'h04;
      4'd4:    rc = 8'h08;
      4'd5:    rc = 8'h10;
      4'd6:    rc = 8'h20;
      4'd7:    rc = 8'h40;
      4'd8:    rc = 8'h80;
      4'd9:    rc = 8'h1b;
      4'd10:   rc = 8'h36;
      default: rc = 8'h00;
    endcase
    return rc;
  endfunction

  // One FIPS-197 Nk=4 step: four chained word XORs behind a single SubWord(RotWord()).
  function automatic logic [127:0] expand_round(input logic [127:0] k, input logic [7:0] rc);
    logic [31:0] w0, w1, w2, w3, t;
    {w0, w1, w2, w3} = k;
    t  = {sbox(w3[23:16]), sbox(w3[15:8]), sbox(w3[7:0]), sbox(w3[31:24])} ^ {rc, 24'h0};
    w0 = w0 ^ t;
    w1 = w1 ^ w0;
    w2 = w2 ^ w1;
    w3 = w3 ^ w2;
    return {w0, w1, w2, w3};
  endfunction

  assign next_key = (round_cnt_q == 4'd0) ? work_key_q
                                          : expand_round(work_key_q, rcon(round_cnt_q));

  // NOTE: every variable gets a default before the case so no path leaves one unassigned (no latches).
  always_comb begin
    state_d       = state_q;
    round_cnt_d   = round_cnt_q;
    work_key_d    = work_key_q;
    round_key_d   = round_key_q;
    round_index_d = round_index_q;
    table_valid_d = table_valid_q;
    key_valid_d   = 1'b0;
    busy_d        = 1'b0;
    done_d        = 1'b0;
    table_we      = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          work_key_d    = cipher_key;
          round_cnt_d   = 4'd0;
          table_valid_d = 1'b0;
          state_d       = EXPAND;
        end
      end
      EXPAND: begin
        work_key_d    = next_key;
        round_key_d   = next_key;
        round_index_d = round_cnt_q;
        key_valid_d   = 1'b1;
        busy_d        = 1'b1;
        table_we      = 1'b1;
        round_cnt_d   = round_cnt_q + 4'd1;
        if (round_cnt_q == LAST_ROUND) begin
          done_d        = 1'b1;
          table_valid_d = 1'b1;
          round_cnt_d   = 4'd0;
          state_d       = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: non-blocking assignments here so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      round_cnt_q   <= '0;
      work_key_q    <= '0;
      round_key_q   <= '0;
      round_index_q <= '0;
      key_valid_q   <= 1'b0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      table_valid_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      round_cnt_q   <= round_cnt_d;
      work_key_q    <= work_key_d;
      round_key_q   <= round_key_d;
      round_index_q <= round_index_d;
      key_valid_q   <= key_valid_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
      table_valid_q <= table_valid_d;
    end
  end

  // NOTE: the table is flops, not RAM, because an aborted expansion must leave it reading all zeros.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < ROUNDS + 1; i++) key_table_q[i] <= '0;
    end else if (table_we) begin
      key_table_q[round_cnt_q] <= next_key;
    end
  end

  // Reads see the registered table, so a same-cycle write is not yet visible.
  always_comb begin
    rd_key = '0;
    if (rd_index <= LAST_ROUND) rd_key = key_table_q[rd_index];
  end

  assign busy            = busy_q;
  assign round_key_valid = key_valid_q;
  assign round_key       = round_key_q;
  assign round_index     = round_index_q;
  assign done            = done_q;
  assign table_valid     = table_valid_q;

endmodule

// File: tb/tb_key_schedule.sv
// Self-checking bench for key_schedule: a word-level FIPS-197 reference model with an
// arithmetically derived S-box, plus an AES round datapath fed from round_key.
module tb_key_schedule;

  logic         clk = 1'b0;
  logic         rst, start;
  logic [0:127] cipher_key;
  logic         busy, round_key_valid, done, table_valid;
  logic [0:127] round_key, rd_key;
  logic [3:0]   round_index, rd_index;

  int checks   = 0;
  int failures = 0;

  logic [7:0]   sbox_m [256];
  logic [127:0] exp_rk [11];
  logic [127:0] obs_rk [11];
  logic [127:0] tbl_m  [11];

  key_schedule #(.ROUNDS(10)) dut (
    .clk(clk), .rst(rst), .start(start), .cipher_key(cipher_key),
    .busy(busy), .round_key_valid(round_key_valid), .round_key(round_key),
    .round_index(round_index), .done(done), .rd_index(rd_index),
    .rd_key(rd_key), .table_valid(table_valid)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    p = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (b[0]) p = p ^ a;
      a = {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
      b = b >> 1;
    end
    return p;
  endfunction

  // S-box from its definition: multiplicative inverse in GF(2^8) then the affine map.
  task automatic build_sbox();
    logic [7:0] inv;
    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      for (int y = 1; y < 256; y++)
        if (x != 0 && gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      sbox_m[x] = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
                  {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    end
  endtask

  task automatic expand_ref(input logic [127:0] key);
    logic [31:0] w [44];
    logic [31:0] t;
    logic [7:0]  rc;
    {w[0], w[1], w[2], w[3]} = key;
    rc = 8'h01;
    for (int j = 4; j < 44; j++) begin
      t = w[j-1];
      if (j % 4 == 0) begin
        t = {sbox_m[t[23:16]], sbox_m[t[15:8]], sbox_m[t[7:0]], sbox_m[t[31:24]]} ^ {rc, 24'h0};
        rc = gmul(rc, 8'h02);
      end
      w[j] = w[j-4] ^ t;
    end
    for (int r = 0; r < 11; r++) exp_rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endtask

  function automatic logic [127:0] sub_bytes(input logic [127:0] s);
    logic [127:0] o;
    for (int i = 0; i < 16; i++) o[127-8*i -: 8] = sbox_m[s[127-8*i -: 8]];
    return o;
  endfunction

  function automatic logic [127:0] shift_rows(input logic [127:0] s);
    logic [127:0] o;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        o[127-8*(4*c+r) -: 8] = s[127-8*(4*((c+r)%4)+r) -: 8];
    return o;
  endfunction

  function automatic logic [127:0] mix_columns(input logic [127:0] s);
    logic [127:0] o;
    logic [7:0] a0, a1, a2, a3;
    for (int c = 0; c < 4; c++) begin
      a0 = s[127-32*c -: 8];
      a1 = s[119-32*c -: 8];
      a2 = s[111-32*c -: 8];
      a3 = s[103-32*c -: 8];
      o[127-32*c -: 8] = gmul(a0, 8'h02) ^ gmul(a1, 8'h03) ^ a2 ^ a3;
      o[119-32*c -: 8] = a0 ^ gmul(a1, 8'h02) ^ gmul(a2, 8'h03) ^ a3;
      o[111-32*c -: 8] = a0 ^ a1 ^ gmul(a2, 8'h02) ^ gmul(a3, 8'h03);
      o[103-32*c -: 8] = gmul(a0, 8'h03) ^ a1 ^ a2 ^ gmul(a3, 8'h02);
    end
    return o;
  endfunction

  task automatic clear_table_model();
    for (int i = 0; i < 11; i++) tbl_m[i] = '0;
  endtask

  // One full expansion; optionally pulses start with glitch_key at edge N+glitch_edge.
  task automatic run_expansion(input logic [127:0] key, input int glitch_edge,
                               input logic [127:0] glitch_key);
    int done_cnt;
    expand_ref(key);
    start = 1'b1;
    cipher_key = key;
    tick();
    start = 1'b0;
    check("busy_after_accept", 128'(busy), 128'(0));
    check("tv_cleared", 128'(table_valid), 128'(0));
    check("rkv_after_accept", 128'(round_key_valid), 128'(0));
    done_cnt = 0;
    for (int i = 0; i < 11; i++) begin
      rd_index = 4'(i);
      #1;
      check($sformatf("rd_before_write%0d", i), rd_key, tbl_m[i]);
      if (i + 1 == glitch_edge) begin
        start = 1'b1;
        cipher_key = glitch_key;
      end
      tick();
      start = 1'b0;
      cipher_key = key;
      obs_rk[i] = round_key;
      check($sformatf("round_key%0d", i), round_key, exp_rk[i]);
      check($sformatf("round_index%0d", i), 128'(round_index), 128'(i));
      check($sformatf("rkv%0d", i), 128'(round_key_valid), 128'(1));
      check($sformatf("busy%0d", i), 128'(busy), 128'(1));
      check($sformatf("done%0d", i), 128'(done), 128'(i == 10));
      check($sformatf("tv%0d", i), 128'(table_valid), 128'(i == 10));
      check($sformatf("rd_after_write%0d", i), rd_key, exp_rk[i]);
      if (done) done_cnt++;
      tbl_m[i] = exp_rk[i];
    end
    tick();
    check("rkv_falls", 128'(round_key_valid), 128'(0));
    check("busy_falls", 128'(busy), 128'(0));
    check("done_one_cycle", 128'(done), 128'(0));
    check("round_key_hold", round_key, exp_rk[10]);
    check("round_index_hold", 128'(round_index), 128'(10));
    check("tv_held", 128'(table_valid), 128'(1));
    for (int k = 0; k < 3; k++) begin
      if (done) done_cnt++;
      tick();
    end
    check("done_count", 128'(done_cnt), 128'(1));
  endtask

  task automatic read_table_check(input string tag);
    for (int i = 0; i < 16; i++) begin
      rd_index = 4'(i);
      #1;
      check($sformatf("%s_rd%0d", tag, i), rd_key, (i <= 10) ? tbl_m[i] : 128'h0);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [127:0] st, key_a;
    int done_cnt, zeros;
    int dq [$];
    logic tv_h [51];

    build_sbox();
    rst = 1'b1;
    start = 1'b0;
    cipher_key = '0;
    rd_index = '0;
    tick();
    tick();
    rst = 1'b0;
    clear_table_model();
    check("rst_busy", 128'(busy), 128'(0));
    check("rst_rkv", 128'(round_key_valid), 128'(0));
    check("rst_done", 128'(done), 128'(0));
    check("rst_tv", 128'(table_valid), 128'(0));
    check("rst_round_key", round_key, 128'h0);
    check("rst_round_index", 128'(round_index), 128'(0));
    read_table_check("rst");

    // FIPS-197 key, then the round datapath driven from the observed round keys.
    run_expansion(128'h2b7e151628aed2a6abf7158809cf4f3c, -1, '0);
    check("fips_r0", obs_rk[0], 128'h2b7e151628aed2a6abf7158809cf4f3c);
    check("fips_r1", obs_rk[1], 128'ha0fafe1788542cb123a339392a6c7605);
    check("fips_r10", obs_rk[10], 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
    st = 128'h3243f6a8885a308d313198a2e0370734 ^ obs_rk[0];
    for (int r = 1; r < 10; r++) st = mix_columns(shift_rows(sub_bytes(st))) ^ obs_rk[r];
    st = shift_rows(sub_bytes(st)) ^ obs_rk[10];
    check("aes_ciphertext", st, 128'h3925841d02dc09fbdc118597196a0b32);

    run_expansion(128'h0, -1, '0);
    check("zero_r1", obs_rk[1], 128'h62636363626363636263636362636363);
    check("zero_r10", obs_rk[10], 128'hb4ef5bcb3e92e21123e951cf6f8f188e);
    rd_index = 4'd1;
    #1;
    check("zero_rd1", rd_key, 128'h62636363626363636263636362636363);
    rd_index = 4'd15;
    #1;
    check("zero_rd15", rd_key, 128'h0);

    for (int n = 0; n < 4; n++)
      run_expansion({$urandom, $urandom, $urandom, $urandom}, -1, '0);
    read_table_check("rand");

    // A second start during expansion must be ignored entirely.
    key_a = {$urandom, $urandom, $urandom, $urandom};
    run_expansion(key_a, 4, {$urandom, $urandom, $urandom, $urandom});

    // Reset at N+5 aborts: everything zero, no done afterwards.
    start = 1'b1;
    cipher_key = {$urandom, $urandom, $urandom, $urandom};
    tick();
    start = 1'b0;
    for (int k = 0; k < 4; k++) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tick();
    clear_table_model();
    check("abort_busy", 128'(busy), 128'(0));
    check("abort_round_key", round_key, 128'h0);
    check("abort_tv", 128'(table_valid), 128'(0));
    check("abort_rkv", 128'(round_key_valid), 128'(0));
    read_table_check("abort");
    done_cnt = 0;
    for (int k = 0; k < 15; k++) begin
      if (done) done_cnt++;
      tick();
    end
    check("abort_no_done", 128'(done_cnt), 128'(0));

    run_expansion({$urandom, $urandom, $urandom, $urandom}, -1, '0);

    // start held high: back-to-back expansions of one fixed key.
    key_a = {$urandom, $urandom, $urandom, $urandom};
    expand_ref(key_a);
    start = 1'b1;
    cipher_key = key_a;
    tv_h[0] = table_valid;
    for (int c = 1; c <= 50; c++) begin
      tick();
      tv_h[c] = table_valid;
      if (done) begin
        dq.push_back(c);
        check($sformatf("cont_rk10_c%0d", c), round_key, exp_rk[10]);
      end
      if (c >= 12) begin
        rd_index = 4'(c % 11);
        #1;
        check($sformatf("cont_table_c%0d", c), rd_key, exp_rk[c % 11]);
      end
    end
    start = 1'b0;
    check("cont_done_count", 128'(dq.size()), 128'(4));
    if (dq.size() > 0) check("cont_first_done", 128'(dq[0]), 128'(12));
    for (int k = 1; k < dq.size(); k++) begin
      check($sformatf("cont_period%0d", k), 128'(dq[k] - dq[k-1]), 128'(12));
      if (dq[k] >= 12) begin
        zeros = 0;
        for (int c = dq[k] - 11; c < dq[k]; c++) if (tv_h[c] == 1'b0) zeros++;
        check($sformatf("cont_tv_low%0d", k), 128'(zeros), 128'(11));
        check($sformatf("cont_tv_before%0d", k), 128'(tv_h[dq[k]-12]), 128'(1));
        check($sformatf("cont_tv_back%0d", k), 128'(tv_h[dq[k]]), 128'(1));
      end
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/key_schedule.md
KEY_SCHEDULE -- requirements
Module: key_schedule

Interface
REQ-001 The parameter list SHALL be: ROUNDS, 10, number of AES-128 rounds; 10 is the only supported value.
REQ-002 The port `clk` SHALL be: input, 1 bit, the single clock; all state changes on its rising edge.
REQ-003 The port `rst` SHALL be: input, 1 bit, reset, synchronous and active-high.
REQ-004 The port `start` SHALL be: input, 1 bit, request to expand `cipher_key`.
REQ-005 The port `cipher_key` SHALL be: input, [0:127], AES-128 key; byte k = bits [8k:8k+7], byte 0 first, MSB-first.
REQ-006 The port `busy` SHALL be: output, 1 bit, high while expansion is in progress.
REQ-007 The port `round_key_valid` SHALL be: output, 1 bit, high when `round_key` and `round_index` carry a new key.
REQ-008 The port `round_key` SHALL be: output, [0:127], the current round key, in the same byte order as `cipher_key`; it drives the round datapath's key input.
REQ-009 The port `round_index` SHALL be: output, [3:0], the round number 0..10 of `round_key`.
REQ-010 The port `done` SHALL be: output, 1 bit, a one-cycle pulse with round key 10.
REQ-011 The port `rd_index` SHALL be: input, [3:0], random-access read address into the stored key table.
REQ-012 The port `rd_key` SHALL be: output, [0:127], a combinational read of the table entry at `rd_index`.
REQ-013 The port `table_valid` SHALL be: output, 1 bit, high when all 11 table entries belong to the last completed expansion.

Function
REQ-014 The FSM SHALL have states IDLE and EXPAND: IDLE goes to EXPAND on `start`=1, and EXPAND returns to IDLE after round 10 is produced.
REQ-015 `start` sampled in IDLE at edge N SHALL capture `cipher_key` into the working register, clear `table_valid`, and enter EXPAND.
REQ-016 Round i key (i=0..10) SHALL be registered at edge N+1+i, with `round_key_valid`=1 and `round_index`=i.
- Round 0 equals `cipher_key`.
- One round is produced per cycle, with no stalls.
REQ-017 Key generation SHALL follow FIPS-197 for Nk=4: w[j] = w[j-4] xor w[j-1] for j mod 4 != 0, and w[j] = w[j-4] xor SubWord(RotWord(w[j-1])) xor Rcon for j mod 4 = 0.
REQ-018 The four words of a round key SHALL be computed combinationally within one cycle, using 4 S-box lookups per round.
REQ-019 The Rcon sequence SHALL be 01,02,04,08,10,20,40,80,1B,36, placed in the most significant byte of the Rcon word, and held in a 4-bit round counter plus a lookup or xtime register.
REQ-020 `busy` SHALL be 1 from edge N+1 through N+11 inclusive and 0 otherwise.
REQ-021 `done` SHALL be 1 only in the cycle after edge N+11, coincident with `round_index`=10.
REQ-022 `round_key_valid` SHALL fall after round 10, while `round_key` and `round_index` hold their last values until the next `start` or `rst`.
REQ-023 Each generated round key SHALL be written into table entry i at the same edge it appears on `round_key`.
REQ-024 `table_valid` SHALL be set together with `done` and remain set until the next accepted `start` or `rst`.
REQ-025 `start` asserted while `busy`=1 SHALL be ignored: no restart, no queueing, and the key is not captured.
REQ-026 `start` held high across completion SHALL begin a new expansion only if sampled in IDLE, i.e. at the earliest one cycle after `done`.
REQ-027 `rd_key` SHALL return all zeros for `rd_index` > 10, and SHALL show partially updated entries during EXPAND, which is why consumers must qualify reads with `table_valid`.
REQ-028 A read and a write to the same entry in the same cycle SHALL return the old value (read-before-write).

Reset
REQ-029 `rst`=1 at an edge SHALL force IDLE and clear every output and internal register to 0: `busy`, `round_key_valid`, `done`, `table_valid`, `round_key`, `round_index`, the round counter, the working key and all 11 table entries.
REQ-030 `rst` SHALL take priority over `start`.
REQ-031 `rst` during EXPAND SHALL abort the expansion with no `done` pulse, and the table SHALL read all zeros afterwards.

Verification
REQ-032 A bench SHALL drive `start` with `cipher_key`=2b7e151628aed2a6abf7158809cf4f3c and check:
- round 0 = the key at N+1;
- round 1 = a0fafe1788542cb123a339392a6c7605 at N+2;
- round 10 = d014f9a8c9ee2589e13f0cc8b6630ca6 at N+11, with `done`=1 in that cycle only.
REQ-033 A bench SHALL drive an all-zero key and check:
- round 1 = 62636363626363636263636362636363;
- round 10 = b4ef5bcb3e92e21123e951cf6f8f188e;
- after `done`, `rd_index`=1 returns the round 1 value and `rd_index`=15 returns 0.
REQ-034 A bench SHALL pulse `start` with a different key at N+4 during expansion and check that all outputs still match the first key and `done` occurs exactly once at N+11.
REQ-035 A bench SHALL assert `rst` at N+5 and check that at N+6 `busy`=0, `round_key`=0, `table_valid`=0 and `rd_key`=0 for all indices, and that no `done` pulse follows.
REQ-036 A bench SHALL hold `start` high continuously with a fixed key and check:
- `done` pulses repeat every 12 cycles;
- `table_valid` drops for 11 cycles and then returns;
- the table values are identical in each run.
REQ-037 A bench SHALL feed `round_key` into the round datapath over rounds 1..10 with FIPS-197 plaintext 3243f6a8885a308d313198a2e0370734, and the final state SHALL be 3925841d02dc09fbdc118597196a0b32.
